// File: rtl/exe_stage.sv
// Execute stage of a five-stage in-order pipeline.
// Holds one decoded instruction, computes its ALU result, issues at most one
// data-SRAM request for loads and stores, and hands the result to the memory stage.
module exe_stage (
  input  logic        clk,
  input  logic        resetn,
  // decode -> execute handshake
  input  logic        ds_to_es_valid,
  output logic        es_allow_in,
  // decoded instruction fields
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [31:0] ds_st_data,
  input  logic [11:0] ds_alu_op,
  input  logic        ds_sram_en,
  input  logic [3:0]  ds_sram_we,
  input  logic [3:0]  ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,
  input  logic [4:0]  ds_rf_raddr1,
  input  logic [4:0]  ds_rf_raddr2,
  // data SRAM request channel
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  // execute -> memory handshake and payload
  input  logic        ms_allow_in,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic [31:0] es_alu_result,
  output logic        es_res_from_mem,
  output logic [3:0]  es_rf_we,
  output logic [4:0]  es_rf_waddr,
  // bypass / hazard information for decode
  output logic [31:0] es_fwd_wdata,
  output logic        es_load_hazard
);

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int          NUM_OPS  = 12;

  // IDLE: no request needed (or already retired); REQ: request on the bus;
  // SENT: request accepted but the memory stage has not taken the instruction yet.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SENT = 2'd2
  } mem_state_t;

  mem_state_t state_reg;
  mem_state_t state_next;

  logic        es_valid;
  logic [31:0] pc_reg;
  logic [31:0] src1_reg;
  logic [31:0] src2_reg;
  logic [31:0] st_data_reg;
  logic [11:0] alu_op_reg;
  logic        sram_en_reg;
  logic [3:0]  sram_we_reg;
  logic [3:0]  rf_we_reg;
  logic [4:0]  rf_waddr_reg;

  logic es_mem_op;
  logic ds_mem_op;
  logic es_ready_go;
  logic accept;
  logic drain;

  logic [NUM_OPS-1:0][31:0] op_res;
  logic [NUM_OPS-1:0][31:0] op_masked;
  logic [31:0]              alu_result;

  // ------------------------------------------------------------------
  // Handshake
  // ------------------------------------------------------------------
  assign es_mem_op   = sram_en_reg || (sram_we_reg != 4'b0);
  assign ds_mem_op   = ds_sram_en || (ds_sram_we != 4'b0);

  // Non-memory ops are ready at once; a memory op is ready in the cycle its
  // request is accepted and stays ready afterwards (SENT).
  assign es_ready_go = !es_mem_op
                     || ((state_reg == REQ) && data_sram_addr_ok)
                     || (state_reg == SENT);

  assign es_allow_in    = !es_valid || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid = es_valid && es_ready_go;
  assign accept         = ds_to_es_valid && es_allow_in;
  assign drain          = es_to_ms_valid && ms_allow_in;

  // Valid flag: a new instruction wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid <= 1'b0;
    end else if (accept) begin
      es_valid <= 1'b1;
    end else if (drain) begin
      es_valid <= 1'b0;
    end
  end

  // Instruction payload register, loaded on every accepted instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg       <= RESET_PC;
      src1_reg     <= '0;
      src2_reg     <= '0;
      st_data_reg  <= '0;
      alu_op_reg   <= '0;
      sram_en_reg  <= 1'b0;
      sram_we_reg  <= '0;
      rf_we_reg    <= '0;
      rf_waddr_reg <= '0;
    end else if (accept) begin
      pc_reg       <= ds_pc;
      src1_reg     <= ds_alu_src1;
      src2_reg     <= ds_alu_src2;
      st_data_reg  <= ds_st_data;
      alu_op_reg   <= ds_alu_op;
      sram_en_reg  <= ds_sram_en;
      sram_we_reg  <= ds_sram_we;
      rf_we_reg    <= ds_rf_we;
      rf_waddr_reg <= ds_rf_waddr;
    end
  end

  // ------------------------------------------------------------------
  // Memory request FSM
  // ------------------------------------------------------------------
  // State register for the request FSM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: a latch always restarts the FSM for the new instruction;
  // otherwise advance once the request is taken and once the result leaves.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = ds_mem_op ? REQ : IDLE;
    end else begin
      case (state_reg)
        REQ: begin
          if (data_sram_addr_ok) begin
            state_next = ms_allow_in ? IDLE : SENT;
          end
        end
        SENT: begin
          if (ms_allow_in) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // Request is only raised in REQ, so an accepted request is never repeated.
  assign data_sram_req   = es_valid && (state_reg == REQ);
  assign data_sram_wr    = (sram_we_reg != 4'b0);
  assign data_sram_we    = sram_we_reg;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = st_data_reg;

  // ------------------------------------------------------------------
  // ALU: every op evaluated in parallel, one-hot select ORs the chosen one
  // ------------------------------------------------------------------
  assign op_res[0]  = src1_reg + src2_reg;
  assign op_res[1]  = src1_reg - src2_reg;
  assign op_res[2]  = {31'b0, ($signed(src1_reg) < $signed(src2_reg))};
  assign op_res[3]  = {31'b0, (src1_reg < src2_reg)};
  assign op_res[4]  = src1_reg & src2_reg;
  assign op_res[5]  = ~(src1_reg | src2_reg);
  assign op_res[6]  = src1_reg | src2_reg;
  assign op_res[7]  = src1_reg ^ src2_reg;
  assign op_res[8]  = src1_reg << src2_reg[4:0];
  assign op_res[9]  = src1_reg >> src2_reg[4:0];
  assign op_res[10] = $signed(src1_reg) >>> src2_reg[4:0];
  assign op_res[11] = src2_reg;

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op_mask
      assign op_masked[gi] = {32{alu_op_reg[gi]}} & op_res[gi];
    end
  endgenerate

  // OR-reduce the masked results; an all-zero op code yields zero.
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      alu_result = alu_result | op_masked[i];
    end
  end

  // ------------------------------------------------------------------
  // Outputs toward memory stage and decode
  // ------------------------------------------------------------------
  assign es_pc           = pc_reg;
  assign es_alu_result   = alu_result;
  assign es_res_from_mem = sram_en_reg;
  assign es_rf_we        = es_valid ? rf_we_reg : 4'b0;
  assign es_rf_waddr     = rf_waddr_reg;
  assign es_fwd_wdata    = alu_result;

  // A load's data is not available for bypass here, so decode must stall
  // when it reads the load's destination (r0 never creates a dependency).
  assign es_load_hazard = es_valid && sram_en_reg && (rf_waddr_reg != 5'd0)
                        && ((rf_waddr_reg == ds_rf_raddr1)
                            || (rf_waddr_reg == ds_rf_raddr2));

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed scenarios plus randomized traffic,
// with expected retirements and memory requests checked by a separate monitor.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ds_to_es_valid;
  logic        es_allow_in;
  logic [31:0] ds_pc, ds_alu_src1, ds_alu_src2, ds_st_data;
  logic [11:0] ds_alu_op;
  logic        ds_sram_en;
  logic [3:0]  ds_sram_we, ds_rf_we;
  logic [4:0]  ds_rf_waddr, ds_rf_raddr1, ds_rf_raddr2;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        ms_allow_in;
  logic        es_to_ms_valid;
  logic [31:0] es_pc, es_alu_result;
  logic        es_res_from_mem;
  logic [3:0]  es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_fwd_wdata;
  logic        es_load_hazard;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .resetn(resetn),
    .ds_to_es_valid(ds_to_es_valid), .es_allow_in(es_allow_in),
    .ds_pc(ds_pc), .ds_alu_src1(ds_alu_src1), .ds_alu_src2(ds_alu_src2),
    .ds_st_data(ds_st_data), .ds_alu_op(ds_alu_op), .ds_sram_en(ds_sram_en),
    .ds_sram_we(ds_sram_we), .ds_rf_we(ds_rf_we), .ds_rf_waddr(ds_rf_waddr),
    .ds_rf_raddr1(ds_rf_raddr1), .ds_rf_raddr2(ds_rf_raddr2),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .ms_allow_in(ms_allow_in), .es_to_ms_valid(es_to_ms_valid),
    .es_pc(es_pc), .es_alu_result(es_alu_result),
    .es_res_from_mem(es_res_from_mem), .es_rf_we(es_rf_we),
    .es_rf_waddr(es_rf_waddr), .es_fwd_wdata(es_fwd_wdata),
    .es_load_hazard(es_load_hazard)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] st;
    logic [11:0] op;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [3:0]  rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
  } instr_t;

  instr_t exp_q[$];
  bit     head_mem_done = 1'b0;
  bit     rand_mode = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     cycle = 0;
  int     retired = 0;
  logic [31:0] next_pc = 32'h0000_1000;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the operation definitions.
  function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [31:0] sign;
    int          s;
    r = 32'h0;
    s = int'(b[4:0]);
    sign = a[31] ? 32'hFFFF_FFFF : 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (op[i]) begin
        case (i)
          0:  r = r | (a + b);
          1:  r = r | (a - b);
          2:  r = r | ((a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)});
          3:  r = r | {31'b0, (a < b)};
          4:  r = r | (a & b);
          5:  r = r | ~(a | b);
          6:  r = r | (a | b);
          7:  r = r | (a ^ b);
          8:  r = r | (a << s);
          9:  r = r | (a >> s);
          10: r = r | (((a ^ sign) >> s) ^ sign);
          default: r = r | b;
        endcase
      end
    end
    return r;
  endfunction

  function automatic bit is_mem(input instr_t t);
    return t.sram_en || (t.sram_we != 4'b0);
  endfunction

  function automatic instr_t mk_alu(input int opi, input logic [31:0] a, input logic [31:0] b);
    instr_t t;
    t.pc = next_pc; t.src1 = a; t.src2 = b; t.st = 32'h0;
    t.op = 12'h0; t.op[opi] = 1'b1;
    t.sram_en = 1'b0; t.sram_we = 4'h0; t.rf_we = 4'hF; t.waddr = 5'd3; t.result = 32'h0;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int k;
    int o;
    k = int'($urandom_range(0, 3));
    o = int'($urandom_range(0, 12));
    t.pc = $urandom & 32'hFFFF_FFFC;
    t.src1 = $urandom;
    t.src2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    t.st = $urandom;
    t.op = 12'h0;
    if (o < 12) t.op[o] = 1'b1;
    t.sram_en = 1'b0; t.sram_we = 4'h0; t.rf_we = 4'hF;
    t.waddr = 5'($urandom_range(0, 7));
    t.result = 32'h0;
    if (k == 2) begin
      t.op = 12'h001; t.sram_en = 1'b1;
    end else if (k == 3) begin
      t.op = 12'h001; t.rf_we = 4'h0;
      case ($urandom_range(0, 6))
        0: t.sram_we = 4'h1;
        1: t.sram_we = 4'h2;
        2: t.sram_we = 4'h4;
        3: t.sram_we = 4'h8;
        4: t.sram_we = 4'h3;
        5: t.sram_we = 4'hC;
        default: t.sram_we = 4'hF;
      endcase
    end
    return t;
  endfunction

  // Present one instruction (call just after a rising edge); returns 1 ns after
  // the edge that latched it, with the expectation queued.
  task automatic issue(input instr_t in);
    int n;
    bit acc;
    n = 0; acc = 1'b0;
    ds_to_es_valid = 1'b1;
    ds_pc = in.pc; ds_alu_src1 = in.src1; ds_alu_src2 = in.src2; ds_st_data = in.st;
    ds_alu_op = in.op; ds_sram_en = in.sram_en; ds_sram_we = in.sram_we;
    ds_rf_we = in.rf_we; ds_rf_waddr = in.waddr;
    next_pc = next_pc + 32'd4;
    while (!acc) begin
      @(negedge clk);
      acc = es_allow_in && resetn;
      @(posedge clk);
      if (acc) begin
        in.result = ref_alu(in.op, in.src1, in.src2);
        exp_q.push_back(in);
      end else if (++n > 200) begin
        chk("accept_timeout", 32'(es_allow_in), 32'h1);
        break;
      end
    end
    #1 ds_to_es_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random environment: backpressure, request acceptance and decode sources.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      ms_allow_in       = ($urandom_range(0, 3) != 0);
      data_sram_addr_ok = ($urandom_range(0, 2) != 0);
      ds_rf_raddr1      = 5'($urandom_range(0, 7));
      ds_rf_raddr2      = 5'($urandom_range(0, 7));
    end
  end

  // Monitor: the queue head is the instruction held by the stage.
  always @(negedge clk) begin
    instr_t h;
    bit     have;
    bit     hz;
    if (resetn) begin
      have = (exp_q.size() != 0);
      if (have) h = exp_q[0];
      hz = have && h.sram_en && (h.waddr != 5'd0)
           && ((h.waddr == ds_rf_raddr1) || (h.waddr == ds_rf_raddr2));
      chk("rf_we", 32'(es_rf_we), have ? 32'(h.rf_we) : 32'h0);
      chk("load_hazard", 32'(es_load_hazard), 32'(hz));
      if (!have) begin
        chk("idle_to_ms_valid", 32'(es_to_ms_valid), 32'h0);
        chk("idle_req", 32'(data_sram_req), 32'h0);
      end else begin
        if (data_sram_req) begin
          if (!is_mem(h) || head_mem_done) begin
            chk("req_unexpected", 32'(data_sram_req), 32'h0);
          end else if (data_sram_addr_ok) begin
            chk("req_addr", data_sram_addr, h.result);
            chk("req_wdata", data_sram_wdata, h.st);
            chk("req_we", 32'(data_sram_we), 32'(h.sram_we));
            chk("req_wr", 32'(data_sram_wr), 32'(h.sram_we != 4'h0));
            head_mem_done = 1'b1;
          end
        end
        if (es_to_ms_valid && ms_allow_in) begin
          chk("ret_pc", es_pc, h.pc);
          chk("ret_result", es_alu_result, h.result);
          chk("ret_fwd", es_fwd_wdata, h.result);
          chk("ret_from_mem", 32'(es_res_from_mem), 32'(h.sram_en));
          chk("ret_waddr", 32'(es_rf_waddr), 32'(h.waddr));
          if (is_mem(h)) chk("ret_mem_req_done", 32'(head_mem_done), 32'h1);
          $display("retire pc=%h result=%h we=%h waddr=%0d", es_pc, es_alu_result,
                   es_rf_we, es_rf_waddr);
          void'(exp_q.pop_front());
          head_mem_done = 1'b0;
          retired++;
        end
      end
    end
  end

  initial begin
    instr_t t;
    int c0;
    int r0;
    int n;
    resetn = 1'b0; ds_to_es_valid = 1'b0;
    ds_pc = '0; ds_alu_src1 = '0; ds_alu_src2 = '0; ds_st_data = '0; ds_alu_op = '0;
    ds_sram_en = 1'b0; ds_sram_we = '0; ds_rf_we = '0; ds_rf_waddr = '0;
    ds_rf_raddr1 = '0; ds_rf_raddr2 = '0;
    data_sram_addr_ok = 1'b0; ms_allow_in = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_pc", es_pc, 32'h1c00_0000);
    chk("rst_to_ms_valid", 32'(es_to_ms_valid), 32'h0);
    chk("rst_req", 32'(data_sram_req), 32'h0);
    chk("rst_rf_we", 32'(es_rf_we), 32'h0);
    chk("rst_hazard", 32'(es_load_hazard), 32'h0);
    chk("rst_allow_in", 32'(es_allow_in), 32'h1);
    step();
    resetn = 1'b1;
    step();

    // add with wraparound, result visible the cycle after the latch
    ms_allow_in = 1'b1;
    issue(mk_alu(0, 32'd5, 32'hFFFF_FFFF));
    @(negedge clk);
    chk("add_valid", 32'(es_to_ms_valid), 32'h1);
    chk("add_result", es_alu_result, 32'd4);
    step();

    // shift / compare corner cases
    issue(mk_alu(10, 32'h8000_0000, 32'h24));
    @(negedge clk);
    chk("sra_result", es_alu_result, 32'hF800_0000);
    step();
    issue(mk_alu(3, 32'd1, 32'hFFFF_FFFF));
    @(negedge clk);
    chk("sltu_result", es_alu_result, 32'd1);
    step();
    issue(mk_alu(2, 32'd1, 32'hFFFF_FFFF));
    @(negedge clk);
    chk("slt_result", es_alu_result, 32'd0);
    step();

    // load held off by addr_ok for three cycles, with a dependent decode
    t = mk_alu(0, 32'h100, 32'h8);
    t.sram_en = 1'b1; t.waddr = 5'd5;
    data_sram_addr_ok = 1'b0; ds_rf_raddr1 = 5'd5; ds_rf_raddr2 = 5'd0;
    issue(t);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld_wait_req", 32'(data_sram_req), 32'h1);
      chk("ld_wait_allow_in", 32'(es_allow_in), 32'h0);
      chk("ld_wait_hazard", 32'(es_load_hazard), 32'h1);
      chk("ld_wait_to_ms", 32'(es_to_ms_valid), 32'h0);
      step();
    end
    data_sram_addr_ok = 1'b1;
    @(negedge clk);
    chk("ld_accept_req", 32'(data_sram_req), 32'h1);
    chk("ld_accept_to_ms", 32'(es_to_ms_valid), 32'h1);
    step();
    data_sram_addr_ok = 1'b0; ds_rf_raddr1 = 5'd0;
    @(negedge clk);
    chk("ld_after_req", 32'(data_sram_req), 32'h0);
    chk("ld_after_to_ms", 32'(es_to_ms_valid), 32'h0);
    step();

    // store accepted while memory stage stalls: one request, then SENT
    t = mk_alu(0, 32'h200, 32'h4);
    t.sram_we = 4'hF; t.rf_we = 4'h0; t.st = 32'hCAFE_F00D;
    ms_allow_in = 1'b0; data_sram_addr_ok = 1'b1;
    issue(t);
    @(negedge clk);
    chk("st_req_first", 32'(data_sram_req), 32'h1);
    chk("st_to_ms_first", 32'(es_to_ms_valid), 32'h1);
    chk("st_allow_in_first", 32'(es_allow_in), 32'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("st_sent_req", 32'(data_sram_req), 32'h0);
      chk("st_sent_to_ms", 32'(es_to_ms_valid), 32'h1);
      step();
    end
    ms_allow_in = 1'b1;
    @(negedge clk);
    chk("st_drain_to_ms", 32'(es_to_ms_valid), 32'h1);
    chk("st_drain_req", 32'(data_sram_req), 32'h0);
    step();
    @(negedge clk);
    chk("st_gone_to_ms", 32'(es_to_ms_valid), 32'h0);
    step();
    data_sram_addr_ok = 1'b0;

    // back-to-back ALU ops retire one per cycle
    c0 = cycle; r0 = retired;
    issue(mk_alu(4, 32'hF0F0_1234, 32'h0FF0_FFFF));
    issue(mk_alu(5, 32'h1234_0000, 32'h0000_5678));
    issue(mk_alu(8, 32'h0000_0001, 32'h0000_001F));
    issue(mk_alu(11, 32'h0, 32'hABCD_E000));
    chk("b2b_cycles", 32'(cycle - c0), 32'd4);
    step();
    chk("b2b_retired", 32'(retired - r0), 32'd4);

    // reset asserted in the middle of a pending request
    t = mk_alu(0, 32'h300, 32'h0);
    t.sram_en = 1'b1; t.waddr = 5'd9;
    issue(t);
    @(negedge clk);
    chk("mid_rst_req_before", 32'(data_sram_req), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_req", 32'(data_sram_req), 32'h0);
    chk("mid_rst_pc", es_pc, 32'h1c00_0000);
    chk("mid_rst_to_ms", 32'(es_to_ms_valid), 32'h0);
    chk("mid_rst_allow_in", 32'(es_allow_in), 32'h1);
    exp_q.delete();
    head_mem_done = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(data_sram_req), 32'h0);
    step();

    // randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      n = int'($urandom_range(0, 2));
      for (int g = 0; g < n; g++) step();
      issue(rand_instr());
    end
    rand_mode = 1'b0;
    step();
    ms_allow_in = 1'b1; data_sram_addr_ok = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: ds_to_es_valid  input  1  decode stage holds a valid instruction.
REQ-004 SHALL have port: es_allow_in  output  1  stage can accept a new instruction this cycle.
REQ-005 SHALL have ports: ds_pc, ds_alu_src1, ds_alu_src2, ds_st_data  input  32 each  decoded operands; st_data is the forwarded rd value for stores.
REQ-006 SHALL have ports: ds_alu_op  input  12  one-hot ALU op; ds_sram_en  input  1  load; ds_sram_we  input  4  store byte enables; ds_rf_we  input  4; ds_rf_waddr  input  5.
REQ-007 SHALL have ports: ds_rf_raddr1, ds_rf_raddr2  input  5 each  decode-stage source registers, used for hazard check.
REQ-008 SHALL have ports: data_sram_req  output  1; data_sram_wr  output  1; data_sram_we  output  4; data_sram_addr  output  32; data_sram_wdata  output  32; data_sram_addr_ok  input  1  request accepted.
REQ-009 SHALL have ports: ms_allow_in  input  1; es_to_ms_valid  output  1; es_pc, es_alu_result  output  32; es_res_from_mem  output  1; es_rf_we  output  4; es_rf_waddr  output  5.
REQ-010 SHALL have ports: es_fwd_wdata  output  32  forwarding data; es_load_hazard  output  1  decode stage must stall.

Function
REQ-011 SHALL latch all ds_* fields and set es_valid on a clock edge where ds_to_es_valid && es_allow_in.
REQ-012 SHALL clear es_valid when es_to_ms_valid && ms_allow_in and no new instruction is latched in the same cycle.
REQ-013 SHALL drive es_allow_in = !es_valid || (es_ready_go && ms_allow_in).
REQ-014 SHALL drive es_to_ms_valid = es_valid && es_ready_go.
REQ-015 SHALL compute es_alu_result combinationally from the latched operands.
  - op0 add; op1 sub; op2 signed slt; op3 unsigned sltu (result 0/1).
  - op4 and; op5 nor; op6 or; op7 xor.
  - op8 sll, op9 srl, op10 sra, each by src2[4:0].
  - op11 pass src2 (lu12i).
  - All arithmetic is mod 2^32.
  - All-zero op gives result 0.
REQ-016 SHALL define es_mem_op = es_sram_en || (es_sram_we != 0).
REQ-017 SHALL implement the memory FSM with states IDLE, REQ and SENT.
  - On latch: enter REQ if the new instruction's mem op is set, else IDLE.
  - In REQ with data_sram_addr_ok: go to SENT if !ms_allow_in; otherwise leave per REQ-017 latch rule, or IDLE if nothing is latched.
  - In SENT with ms_allow_in: leave per the same rule.
REQ-018 SHALL drive data_sram_req = es_valid && state==REQ, with these request fields:
  - data_sram_wr = (es_sram_we != 0).
  - data_sram_we = es_sram_we.
  - data_sram_addr = es_alu_result.
  - data_sram_wdata = latched st_data.
REQ-019 SHALL drive es_ready_go = !es_mem_op || (state==REQ && data_sram_addr_ok) || state==SENT.
REQ-020 SHALL issue each memory request exactly once per instruction; no re-request is made while in SENT.
REQ-021 SHALL drive es_res_from_mem = es_sram_en.
REQ-022 SHALL drive es_rf_we = es_valid ? latched rf_we : 4'b0, and es_fwd_wdata = es_alu_result.
REQ-023 SHALL assert es_load_hazard = es_valid && es_sram_en && es_rf_waddr!=0 && (es_rf_waddr==ds_rf_raddr1 || es_rf_waddr==ds_rf_raddr2).
REQ-024 SHALL let a simultaneous drain and accept latch the new instruction, keep es_valid=1, and set the state for the new instruction.

Reset
REQ-025 SHALL, while resetn=0, asynchronously set:
  - es_valid=0 and state=IDLE.
  - es_pc=32'h1c000000.
  - All other latched fields to 0.
  - All outputs inactive: data_sram_req=0, es_to_ms_valid=0, es_rf_we=0, es_load_hazard=0.
REQ-026 SHALL, on reset assertion mid-request (state REQ or SENT), drop data_sram_req within the same cycle and discard the instruction.

Verification
REQ-027 add: src1=5, src2=0xFFFFFFFF, op0, ms_allow_in=1 -> es_alu_result=4, es_to_ms_valid=1 in the cycle after the latch.
REQ-028 shift/compare:
  - sra src1=0x80000000, src2=0x24 -> 0xF8000000.
  - sltu src1=1, src2=0xFFFFFFFF -> 1.
  - slt same operands -> 0.
REQ-029 load with data_sram_addr_ok low for 3 cycles:
  - data_sram_req held 3 cycles plus the accept cycle.
  - es_allow_in=0 throughout.
  - es_load_hazard=1 when ds_rf_raddr1 equals the load's rf_waddr (nonzero).
REQ-030 store with ms_allow_in=0 while addr_ok=1:
  - Exactly one req cycle, then state SENT.
  - No further req.
  - es_to_ms_valid held until ms_allow_in=1.
REQ-031 back-to-back ALU ops with ms_allow_in=1 -> one instruction retires per cycle; es_allow_in stays 1.
REQ-032 resetn low during REQ -> data_sram_req=0 immediately, es_pc=0x1c000000, es_valid=0.
